// File: rtl/shift_seq_counter.sv
// shift_seq_counter
//   Run-time selectable shift-register sequence generator: ring counter,
//   Johnson (twisted-ring) counter or Fibonacci LFSR, plus a hold mode.
//   A wrap pulse marks the return to the sequence start value.
//   A lock-up pulse marks recovery from the all-zero ring/LFSR trap.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   en          step enable
//   mode[1:0]   00 ring, 01 Johnson, 10 LFSR, 11 hold
//   dir         0 shift toward bit 0, 1 shift toward MSB (ignored for LFSR)
//   load        parallel load strobe (wins over mode change and step)
//   load_val    value to load; all-zero is accepted
//   count       current state (registered)
//   wrap        one-cycle pulse, a step returned count to the start value
//   lockup_err  one-cycle pulse, the counter left the all-zero lock-up state
//
// mode_q | meaning
// -------+-------------------------------------------------
// RING   | rotate count by one bit per step
// JOHN   | shift, feeding back the inverted outgoing bit
// LFSR   | shift right, MSB fed by XOR of tapped bits
// HOLD   | count frozen even with en=1; never wraps

module shift_seq_counter #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b0011,
  parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lockup_err
);

  typedef enum logic [1:0] {
    MODE_RING = 2'b00,
    MODE_JOHN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_in;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_val;
  logic             lockup;

  assign mode_in = mode_t'(mode);

  always_comb begin
    step_val = count;
    case (mode_q)
      MODE_RING: step_val = dir ? {count[WIDTH-2:0], count[WIDTH-1]}
                                : {count[0], count[WIDTH-1:1]};
      MODE_JOHN: step_val = dir ? {count[WIDTH-2:0], ~count[WIDTH-1]}
                                : {~count[0], count[WIDTH-1:1]};
      MODE_LFSR: step_val = {^(count & TAPS), count[WIDTH-1:1]};
      default:   step_val = count;
    endcase
  end

  // All-zero is a fixed point of ring rotation and of an XOR-feedback LFSR.
  // Johnson escapes it on its own, so only ring and LFSR need recovery.
  assign lockup = ((mode_q == MODE_RING) || (mode_q == MODE_LFSR)) &&
                  (count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= SEED;
      start      <= SEED;
      mode_q     <= mode_in;
      wrap       <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      lockup_err <= 1'b0;
      if (load) begin
        count <= load_val;
        start <= load_val;
      end else if (mode_in != mode_q) begin
        // The new sequence starts from wherever the old one left off.
        mode_q <= mode_in;
        start  <= count;
      end else if (en && (mode_q != MODE_HOLD)) begin
        if (lockup) begin
          count      <= SEED;
          start      <= SEED;
          lockup_err <= 1'b1;
        end else begin
          count <= step_val;
          wrap  <= (step_val == start);
        end
      end
    end
  end

endmodule
